// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared constants for the multiplexed 7-segment scan controller.
//   - register word offsets (byte offset >> 2, compared against addr[3:2])
//   - CTRL bit positions
//   - hex-to-segment table, active-low, bit order {A,B,C,D,E,F,G,DP}
//   - all-dark segment pattern
package seg_scan_pkg;

    localparam logic [1:0] SEG_DATA_OFS  = 2'd0;  // byte offset 0x0
    localparam logic [1:0] SEG_DP_OFS    = 2'd1;  // byte offset 0x4
    localparam logic [1:0] SEG_BLANK_OFS = 2'd2;  // byte offset 0x8
    localparam logic [1:0] SEG_CTRL_OFS  = 2'd3;  // byte offset 0xC

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_LZS_BIT  = 1;
    localparam int CTRL_DUTY_LSB = 4;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Entry n is the pattern for hex digit n; DP bit (bit 0) is stored off.
    localparam logic [15:0][7:0] SEG_HEX_TABLE = {
        8'h71,  // F
        8'h61,  // E
        8'h85,  // d
        8'h63,  // C
        8'hC1,  // b
        8'h11,  // A
        8'h09,  // 9
        8'h01,  // 8
        8'h1F,  // 7
        8'h41,  // 6
        8'h49,  // 5
        8'h99,  // 4
        8'h0D,  // 3
        8'h25,  // 2
        8'h9F,  // 1
        8'h03   // 0
    };

endpackage

// File: rtl/seg_scan_ctrl_decoder.sv
// seg_hex_decoder: combinational nibble -> active-low segment pattern.
// Ports:
//   nibble  in  4  hex value to display
//   dp      in  1  1 = light the decimal point
//   blank   in  1  1 = segments A-G dark (DP still follows dp)
//   seg     out 8  {A,B,C,D,E,F,G,DP}, active-low
module seg_hex_decoder
    import seg_scan_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_HEX_TABLE[nibble];
        if (blank) begin
            seg = SEG_BLANK;
        end
        seg[0] = ~dp;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: memory-mapped multiplexed 7-segment display controller.
// Optional feature macro: SEG_SCAN_PWM_EN (per-digit duty-cycle dimming via CTRL[7:4]).
// Ports:
//   clk     in  1           system clock
//   rst     in  1           asynchronous, active-high reset
//   addr    in  ADDR_W      byte offset; only addr[3:2] decoded
//   wen     in  1           write strobe, one cycle per write
//   wdata   in  32          write data
//   rdata   out 32          readback, combinational from addr
//   dig_en  out NUM_DIGITS  digit enables, active-low, at most one low
//   seg     out 8           {A,B,C,D,E,F,G,DP}, active-low
// Bus: a write completes on the clk edge where wen=1 (no wait states, no
// ready); reads are combinational and always valid.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int ADDR_W     = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  wen,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic [7:0]            seg
);

    localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DATA_W = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [DATA_W-1:0]     data_r;
    logic [NUM_DIGITS-1:0] dp_r;
    logic [NUM_DIGITS-1:0] blank_r;
    logic                  en_r;
    logic                  lzs_r;
    logic [3:0]            duty_rd;

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    // Low for exactly the first edge after reset so the outputs stay dark there.
    logic                  started;

    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic                  lz_sup;
    logic                  upper_zero;
    logic [NUM_DIGITS-1:0] onehot;
    logic [7:0]            dec_seg;
    logic                  pwm_on;

    // Address bits outside addr[3:2] and surplus wdata bits are intentionally ignored.
    logic                  unused_bits;
    assign unused_bits = ^{addr[ADDR_W-1:4], addr[1:0], wdata};

`ifdef SEG_SCAN_PWM_EN
    localparam int SLOT_LEN = SCAN_DIV / 16;
    logic [3:0] duty_r;
    assign duty_rd = duty_r;
    // Enabled during the first DUTY+1 slots; full duty also covers any
    // remainder cycles left over by the integer division.
    always_comb begin
        pwm_on = (duty_r == 4'hF) || (int'(cnt) < (int'(duty_r) + 1) * SLOT_LEN);
    end
`else
    assign duty_rd = 4'h0;
    assign pwm_on  = 1'b1;
`endif

    // Register file
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r  <= '0;
            dp_r    <= '0;
            blank_r <= '0;
            en_r    <= 1'b1;
            lzs_r   <= 1'b0;
`ifdef SEG_SCAN_PWM_EN
            duty_r  <= 4'hF;
`endif
        end else if (wen) begin
            case (addr[3:2])
                SEG_DATA_OFS:  data_r  <= wdata[DATA_W-1:0];
                SEG_DP_OFS:    dp_r    <= wdata[NUM_DIGITS-1:0];
                SEG_BLANK_OFS: blank_r <= wdata[NUM_DIGITS-1:0];
                SEG_CTRL_OFS: begin
                    en_r  <= wdata[CTRL_EN_BIT];
                    lzs_r <= wdata[CTRL_LZS_BIT];
`ifdef SEG_SCAN_PWM_EN
                    duty_r <= wdata[CTRL_DUTY_LSB +: 4];
`endif
                end
                default: ;
            endcase
        end
    end

    // Prescaler and digit index; held at 0 while disabled so re-enable starts at digit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (!en_r) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Select the active digit's fields. upper_zero accumulates from the top
    // digit downward, so at digit i it means nibbles i..NUM_DIGITS-1 are zero.
    always_comb begin
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        lz_sup     = 1'b0;
        upper_zero = 1'b1;
        onehot     = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero & (data_r[4*i +: 4] == 4'h0);
            if (IDX_W'(i) == idx) begin
                cur_nib   = data_r[4*i +: 4];
                cur_dp    = dp_r[i];
                cur_blank = blank_r[i];
                lz_sup    = lzs_r && (i != 0) && upper_zero;
                onehot[i] = 1'b1;
            end
        end
    end

    // BLANK darkens DP too; leading-zero suppression leaves DP alone.
    seg_hex_decoder u_dec (
        .nibble (cur_nib),
        .dp     (cur_dp & ~cur_blank),
        .blank  (cur_blank | lz_sup),
        .seg    (dec_seg)
    );

    // Registered outputs, one cycle behind idx.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            started <= 1'b0;
            dig_en  <= '1;
            seg     <= SEG_BLANK;
        end else begin
            started <= 1'b1;
            if (started && en_r) begin
                dig_en <= ~(onehot & {NUM_DIGITS{pwm_on}});
                seg    <= dec_seg;
            end else begin
                dig_en <= '1;
                seg    <= SEG_BLANK;
            end
        end
    end

    // Readback
    always_comb begin
        rdata = '0;
        case (addr[3:2])
            SEG_DATA_OFS:  rdata[DATA_W-1:0]     = data_r;
            SEG_DP_OFS:    rdata[NUM_DIGITS-1:0] = dp_r;
            SEG_BLANK_OFS: rdata[NUM_DIGITS-1:0] = blank_r;
            SEG_CTRL_OFS: begin
                rdata[CTRL_EN_BIT]          = en_r;
                rdata[CTRL_LZS_BIT]         = lzs_r;
                rdata[CTRL_DUTY_LSB +: 4]   = duty_rd;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized + directed bench for seg_scan_ctrl.
// Two instances share the bus: 8 digits (fast scan) and 4 digits / SCAN_DIV=32.
// A behavioural model predicts each edge's outputs from a scan-time counter
// and pushes them into expected queues; a monitor pops and compares on negedge.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

`ifdef SEG_SCAN_PWM_EN
    localparam int SD8 = 16;
    localparam bit PWM = 1'b1;
`else
    localparam int SD8 = 4;
    localparam bit PWM = 1'b0;
`endif
    localparam int N8  = 8;
    localparam int N4  = 4;
    localparam int SD4 = 32;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] addr = '0;
    logic        wen = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata8, rdata4;
    logic [7:0]  dig_en8, seg8, seg4;
    logic [3:0]  dig_en4;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.NUM_DIGITS(N8), .SCAN_DIV(SD8), .ADDR_W(12)) u_dut8 (
        .clk(clk), .rst(rst), .addr(addr), .wen(wen), .wdata(wdata),
        .rdata(rdata8), .dig_en(dig_en8), .seg(seg8)
    );

    seg_scan_ctrl #(.NUM_DIGITS(N4), .SCAN_DIV(SD4), .ADDR_W(12)) u_dut4 (
        .clk(clk), .rst(rst), .addr(addr), .wen(wen), .wdata(wdata),
        .rdata(rdata4), .dig_en(dig_en4), .seg(seg4)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] data;
        logic [7:0]  dp;
        logic [7:0]  blank;
        bit          en;
        bit          lzs;
        logic [3:0]  duty;
        bit          started;
        int          t;       // cycles elapsed since scanning (re)started
    } model_t;

    model_t m8, m4;
    logic [15:0] exp_q8[$];
    logic [11:0] exp_q4[$];
    int checks = 0;
    int errors = 0;

    // Lit segments {A..G}, active-high, for each hex value.
    function automatic logic [6:0] lit_segs(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;
            4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;
            4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r.data = '0; r.dp = '0; r.blank = '0; r.en = 1'b1; r.lzs = 1'b0;
        r.duty = 4'hF; r.started = 1'b0; r.t = 0;
        return r;
    endfunction

    // Returns {dig_en padded to 8 bits with 1s, seg} for the edge that uses state m.
    function automatic logic [15:0] expect_out(input model_t m, input int n, input int sd);
        logic [7:0] en_v;
        logic [7:0] s;
        int         d;
        bit         dark;
        bit         pwm_on;
        en_v = 8'hFF;
        s    = 8'hFF;
        if (m.started && m.en) begin
            d    = (m.t / sd) % n;
            dark = m.blank[d] || (m.lzs && d != 0 && (m.data >> (4 * d)) == 32'h0);
            s    = dark ? 8'hFF : {~lit_segs(4'(m.data >> (4 * d))), 1'b1};
            s[0] = ~(m.dp[d] && !m.blank[d]);
            pwm_on = !PWM || m.duty == 4'hF || (m.t % sd) < (int'(m.duty) + 1) * (sd / 16);
            if (pwm_on) en_v[d] = 1'b0;
        end
        return {en_v, s};
    endfunction

    function automatic model_t model_step(input model_t m, input int n, input bit w,
                                          input logic [11:0] a, input logic [31:0] wd);
        model_t r;
        logic [31:0] dmask;
        logic [7:0]  nmask;
        r = m;
        dmask = (n >= 8) ? 32'hFFFF_FFFF : ((32'h1 << (4 * n)) - 32'h1);
        nmask = 8'((16'h1 << n) - 16'h1);
        r.started = 1'b1;
        r.t = m.en ? m.t + 1 : 0;
        if (w) begin
            case (a[3:2])
                2'd0: r.data  = wd & dmask;
                2'd1: r.dp    = wd[7:0] & nmask;
                2'd2: r.blank = wd[7:0] & nmask;
                default: begin
                    r.en  = wd[0];
                    r.lzs = wd[1];
                    if (PWM) r.duty = wd[7:4];
                end
            endcase
        end
        return r;
    endfunction

    function automatic logic [31:0] readback(input model_t m, input logic [1:0] w);
        case (w)
            2'd0: return m.data;
            2'd1: return {24'h0, m.dp};
            2'd2: return {24'h0, m.blank};
            default: return {24'h0, (PWM ? m.duty : 4'h0), 2'b00, m.lzs, m.en};
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [15:0] e4;
        if (rst) begin
            m8 = model_reset();
            m4 = model_reset();
            exp_q8.delete();
            exp_q4.delete();
        end else begin
            exp_q8.push_back(expect_out(m8, N8, SD8));
            e4 = expect_out(m4, N4, SD4);
            exp_q4.push_back(e4[11:0]);
            m8 = model_step(m8, N8, wen, addr, wdata);
            m4 = model_step(m4, N4, wen, addr, wdata);
        end
    end

    // ---------------- scoreboard / monitor ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [15:0] e8;
        logic [11:0] e4;
        if (rst) begin
            check("reset_out8", {dig_en8, seg8}, 32'hFFFF);
            check("reset_out4", {dig_en4, seg4}, 32'hFFF);
        end else begin
            if (exp_q8.size() > 0) begin
                e8 = exp_q8.pop_front();
                check("scan8", {dig_en8, seg8}, {16'h0, e8});
            end
            if (exp_q4.size() > 0) begin
                e4 = exp_q4.pop_front();
                check("scan4", {dig_en4, seg4}, {20'h0, e4});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic write_reg(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        wen   = 1'b1;
        @(negedge clk);
        wen   = 1'b0;
    endtask

    task automatic read_model(input logic [11:0] a);
        @(negedge clk);
        wen  = 1'b0;
        addr = a;
        #1;
        check("rd8", rdata8, readback(m8, a[3:2]));
        check("rd4", rdata4, readback(m4, a[3:2]));
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    localparam logic [31:0] CTRL_ON = PWM ? 32'hF1 : 32'h01;

    // ---------------- stimulus ----------------
    initial begin
        bit found;
        logic [11:0] a;

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset readback values
        addr = 12'h000; #1; check("rst_data", rdata8, 32'h0);
        addr = 12'h004; #1; check("rst_dp", rdata8, 32'h0);
        addr = 12'h008; #1; check("rst_blank", rdata8, 32'h0);
        addr = 12'h00C; #1; check("rst_ctrl", rdata8, PWM ? 32'hF1 : 32'h01);

        // 1: basic scan of 1234_ABCD
        write_reg(12'h000, 32'h1234_ABCD);
        run(SD8 * N8 * 2 + 4);

        // 2: leading-zero suppression
        write_reg(12'h000, 32'h0000_00A0);
        write_reg(12'h00C, 32'h3);
        run(SD8 * N8 * 2);
        write_reg(12'h000, 32'h0);
        run(SD8 * N8 * 2);

        // 3: DP / BLANK masks
        write_reg(12'h00C, CTRL_ON);
        write_reg(12'h000, 32'h1234_ABCD);
        write_reg(12'h004, 32'h05);
        write_reg(12'h008, 32'h80);
        run(SD8 * N8 * 2);
        addr = 12'h004; #1; check("dp_readback", rdata8, 32'h05);
        addr = 12'h008; #1; check("blank_readback", rdata8, 32'h80);
        check("blank_readback4", rdata4, 32'h0);

        // 4: enable toggle while digit 5 is lit
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (dig_en8 == 8'hDF) found = 1'b1;
        end
        check("digit5_seen", {31'h0, found}, 32'h1);
        write_reg(12'h00C, 32'h0);
        @(posedge clk); #1;
        check("dis_dig_en", {24'h0, dig_en8}, 32'hFF);
        check("dis_seg", {24'h0, seg8}, 32'hFF);
        run(5);
        write_reg(12'h00C, CTRL_ON);
        @(posedge clk); #1;
        check("reen_digit0", {24'h0, dig_en8}, 32'hFE);
        run(SD8 * N8);

        // 6: 4-digit instance masking and wrap, then duty test
        write_reg(12'h000, 32'h1234_ABCD);
        addr = 12'h000; #1;
        check("data4_mask", rdata4, 32'h0000_ABCD);
        check("data8_full", rdata8, 32'h1234_ABCD);
        run(SD4 * N4 * 2 + 8);
        write_reg(12'h00C, 32'h11);
        run(SD4 * N4 * 2);
        read_model(12'h00C);
        write_reg(12'h00C, CTRL_ON);

        // Random register traffic with model readback
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            a = 12'($urandom_range(0, 3) << 2) | 12'($urandom_range(0, 3) << 4);
            if ($urandom_range(0, 7) == 0) begin
                addr  = a;
                wdata = $urandom;
                if (a[3:2] == 2'd3 && $urandom_range(0, 3) != 0) wdata[0] = 1'b1;
                wen   = 1'b1;
            end else begin
                wen  = 1'b0;
                addr = a;
                #1;
                check("rand_rd8", rdata8, readback(m8, a[3:2]));
                check("rand_rd4", rdata4, readback(m4, a[3:2]));
            end
        end
        wen = 1'b0;
        write_reg(12'h00C, CTRL_ON);
        write_reg(12'h004, 32'h5A);
        run(SD8 * N8 + 3);

        // 5: asynchronous reset between edges
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst_dig_en8", {24'h0, dig_en8}, 32'hFF);
        check("arst_seg8", {24'h0, seg8}, 32'hFF);
        check("arst_dig_en4", {28'h0, dig_en4}, 32'hF);
        addr = 12'h000; #1; check("arst_data", rdata8, 32'h0);
        addr = 12'h004; #1; check("arst_dp", rdata8, 32'h0);
        addr = 12'h008; #1; check("arst_blank", rdata8, 32'h0);
        addr = 12'h00C; #1; check("arst_ctrl", rdata8, PWM ? 32'hF1 : 32'h01);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("first_edge_dark", {24'h0, dig_en8}, 32'hFF);
        @(posedge clk); #1;
        check("second_edge_digit0", {24'h0, dig_en8}, 32'hFE);
        run(SD8 * N8 + 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
